rv_mem_wb: RTL and testbench

Memory/write-back stage of the RISC-V 5-stage pipeline. It takes the executed instruction in Q103H, performs the data-memory access over a valid/ready request and valid response interface, and aligns and extends load data. It selects the write-back source and registers the Q104H write port (`wb_data_Q104H`, `rd_Q104H`, `reg_write_en_Q104H`) that feeds the register file and same-cycle bypass in decode. It back-pressures the pipeline while a memory access is outstanding.

---
 rtl/rv_mem_wb.sv | 193 +++++++++++++++++++
 tb/tb_rv_mem_wb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_wb.sv
// Memory/write-back stage: data-memory access with back-pressure, load alignment
// and the registered Q104H register-file write port.
//   state    | meaning
//   IDLE     | no access outstanding; non-mem ops complete here
//   REQ      | request offered, waiting for dmem_req_ready
//   WAIT_RSP | load accepted, waiting for dmem_rsp_valid
module rv_mem_wb #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_Q103H,
  input  logic [31:0] alu_out_Q103H,
  input  logic [31:0] pc_plus4_Q103H,
  input  logic [31:0] store_data_Q103H,
  input  logic [4:0]  rd_Q103H,
  input  logic        reg_write_en_Q103H,
  input  logic        mem_rd_en_Q103H,
  input  logic        mem_wr_en_Q103H,
  input  logic [1:0]  mem_size_Q103H,
  input  logic        mem_unsigned_Q103H,
  input  logic [1:0]  wb_sel_Q103H,
  output logic        stall_Q103H,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  output logic [31:0] wb_data_Q104H,
  output logic [4:0]  rd_Q104H,
  output logic        reg_write_en_Q104H,
  output logic        misaligned_Q104H,
  output logic        timeout_Q104H
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          req_valid;
  logic          complete;
  logic          abort;
  logic          mem_op;
  logic          misaligned;
  logic          mis_evt;
  logic          wait_done;
  logic [1:0]    a;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   load_data;
  logic [31:0]   wb_sel_data;

  assign a          = alu_out_Q103H[1:0];
  assign mem_op     = valid_Q103H & (mem_rd_en_Q103H | mem_wr_en_Q103H);
  assign misaligned = ((mem_size_Q103H == 2'b01) & a[0]) |
                      (mem_size_Q103H[1] & (a != 2'b00));
  assign mis_evt    = (state == IDLE) & mem_op & misaligned;
  // >= also covers a load accepted on the very last REQ cycle
  assign wait_done  = wait_cnt >= LAST_CNT;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_valid    = 1'b0;
    complete     = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (mem_op & ~misaligned) begin
          req_valid = 1'b1;
          if (dmem_req_ready) begin
            if (mem_wr_en_Q103H) complete = 1'b1;
            else                 state_nxt = WAIT_RSP;
          end else begin
            state_nxt = REQ;
          end
        end else begin
          complete = 1'b1;
        end
      end
      REQ: begin
        wait_cnt_nxt = wait_cnt + CW'(1);
        req_valid    = 1'b1;
        if (dmem_req_ready) begin
          if (mem_wr_en_Q103H) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_RSP;
          end
        end else if (wait_done) begin
          complete  = 1'b1;
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RSP: begin
        wait_cnt_nxt = wait_cnt + CW'(1);
        if (dmem_rsp_valid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (wait_done) begin
          complete  = 1'b1;
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dmem_req_valid = req_valid & ~rst;
  assign stall_Q103H    = valid_Q103H & ~complete & ~rst;
  assign dmem_addr      = {alu_out_Q103H[31:2], 2'b00};
  assign dmem_we        = mem_wr_en_Q103H;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = store_data_Q103H;
    if (mem_wr_en_Q103H) begin
      case (mem_size_Q103H)
        2'b00: begin
          dmem_be    = 4'b0001 << a;
          dmem_wdata = {4{store_data_Q103H[7:0]}};
        end
        2'b01: begin
          dmem_be    = a[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{store_data_Q103H[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = store_data_Q103H;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rsp_data[7:0];
    case (a)
      2'd1:    ld_byte = dmem_rsp_data[15:8];
      2'd2:    ld_byte = dmem_rsp_data[23:16];
      2'd3:    ld_byte = dmem_rsp_data[31:24];
      default: ld_byte = dmem_rsp_data[7:0];
    endcase
    ld_half = a[1] ? dmem_rsp_data[31:16] : dmem_rsp_data[15:0];
    case (mem_size_Q103H)
      2'b00:   load_data = {{24{ld_byte[7] & ~mem_unsigned_Q103H}}, ld_byte};
      2'b01:   load_data = {{16{ld_half[15] & ~mem_unsigned_Q103H}}, ld_half};
      default: load_data = dmem_rsp_data;
    endcase
    case (wb_sel_Q103H)
      2'b01:   wb_sel_data = load_data;
      2'b10:   wb_sel_data = pc_plus4_Q103H;
      default: wb_sel_data = alu_out_Q103H;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      wb_data_Q104H      <= '0;
      rd_Q104H           <= '0;
      reg_write_en_Q104H <= 1'b0;
      misaligned_Q104H   <= 1'b0;
      timeout_Q104H      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (complete) begin
        wb_data_Q104H      <= wb_sel_data;
        rd_Q104H           <= rd_Q103H;
        reg_write_en_Q104H <= valid_Q103H & reg_write_en_Q103H & (rd_Q103H != 5'd0) &
                              ~abort & ~mis_evt;
        misaligned_Q104H   <= mis_evt;
        timeout_Q104H      <= abort;
      end else begin
        reg_write_en_Q104H <= 1'b0;
        misaligned_Q104H   <= 1'b0;
        timeout_Q104H      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_wb.sv
// Directed bench for rv_mem_wb: one instance with a long timeout for the
// functional sequence and one with MAX_WAIT=4 for the abort case.
module tb_rv_mem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_Q103H;
  logic [31:0] alu_out_Q103H;
  logic [31:0] pc_plus4_Q103H;
  logic [31:0] store_data_Q103H;
  logic [4:0]  rd_Q103H;
  logic        reg_write_en_Q103H;
  logic        mem_rd_en_Q103H;
  logic        mem_wr_en_Q103H;
  logic [1:0]  mem_size_Q103H;
  logic        mem_unsigned_Q103H;
  logic [1:0]  wb_sel_Q103H;
  logic        dmem_req_ready;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;

  logic        stall, req_valid, we, rwe, mis, tmo;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  rd_o;

  logic        t4_stall, t4_req_valid, t4_we, t4_rwe, t4_mis, t4_tmo;
  logic [31:0] t4_addr, t4_wdata, t4_wb_data;
  logic [3:0]  t4_be;
  logic [4:0]  t4_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv_mem_wb #(.MAX_WAIT(8)) u_dut (
    .clk(clk), .rst(rst), .valid_Q103H(valid_Q103H), .alu_out_Q103H(alu_out_Q103H),
    .pc_plus4_Q103H(pc_plus4_Q103H), .store_data_Q103H(store_data_Q103H),
    .rd_Q103H(rd_Q103H), .reg_write_en_Q103H(reg_write_en_Q103H),
    .mem_rd_en_Q103H(mem_rd_en_Q103H), .mem_wr_en_Q103H(mem_wr_en_Q103H),
    .mem_size_Q103H(mem_size_Q103H), .mem_unsigned_Q103H(mem_unsigned_Q103H),
    .wb_sel_Q103H(wb_sel_Q103H), .stall_Q103H(stall), .dmem_req_valid(req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(addr), .dmem_we(we), .dmem_be(be),
    .dmem_wdata(wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .wb_data_Q104H(wb_data), .rd_Q104H(rd_o), .reg_write_en_Q104H(rwe),
    .misaligned_Q104H(mis), .timeout_Q104H(tmo)
  );

  rv_mem_wb #(.MAX_WAIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .valid_Q103H(valid_Q103H), .alu_out_Q103H(alu_out_Q103H),
    .pc_plus4_Q103H(pc_plus4_Q103H), .store_data_Q103H(store_data_Q103H),
    .rd_Q103H(rd_Q103H), .reg_write_en_Q103H(reg_write_en_Q103H),
    .mem_rd_en_Q103H(mem_rd_en_Q103H), .mem_wr_en_Q103H(mem_wr_en_Q103H),
    .mem_size_Q103H(mem_size_Q103H), .mem_unsigned_Q103H(mem_unsigned_Q103H),
    .wb_sel_Q103H(wb_sel_Q103H), .stall_Q103H(t4_stall), .dmem_req_valid(t4_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(t4_addr), .dmem_we(t4_we), .dmem_be(t4_be),
    .dmem_wdata(t4_wdata), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .wb_data_Q104H(t4_wb_data), .rd_Q104H(t4_rd), .reg_write_en_Q104H(t4_rwe),
    .misaligned_Q104H(t4_mis), .timeout_Q104H(t4_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_Q103H        = 1'b0;
    alu_out_Q103H      = '0;
    pc_plus4_Q103H     = '0;
    store_data_Q103H   = '0;
    rd_Q103H           = '0;
    reg_write_en_Q103H = 1'b0;
    mem_rd_en_Q103H    = 1'b0;
    mem_wr_en_Q103H    = 1'b0;
    mem_size_Q103H     = 2'b00;
    mem_unsigned_Q103H = 1'b0;
    wb_sel_Q103H       = 2'b00;
    dmem_req_ready     = 1'b0;
    dmem_rsp_valid     = 1'b0;
    dmem_rsp_data      = '0;
  endtask

  // Load accepted immediately, response the following cycle.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [4:0] rdn, input logic [31:0] rsp,
                         input logic [31:0] exp_data, input logic exp_we);
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = a; rd_Q103H = rdn; reg_write_en_Q103H = 1'b1;
    mem_rd_en_Q103H = 1'b1; mem_size_Q103H = sz; mem_unsigned_Q103H = uns;
    wb_sel_Q103H = 2'b01; dmem_req_ready = 1'b1;
    #1;
    chk({tag, "_req"}, req_valid, 1);
    chk({tag, "_stall0"}, stall, 1);
    tick();
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rsp_data = rsp;
    #1;
    chk({tag, "_stall1"}, stall, 0);
    tick();
    chk({tag, "_wb"}, wb_data, exp_data);
    chk({tag, "_we"}, rwe, exp_we);
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick(); tick();
    chk("rst_wb", wb_data, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_we", rwe, 0);
    chk("rst_mis", mis, 0);
    chk("rst_to", tmo, 0);
    rst = 1'b0;

    // ADD
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h1234; rd_Q103H = 5'd5; reg_write_en_Q103H = 1'b1;
    #1;
    chk("add_stall", stall, 0);
    chk("add_req", req_valid, 0);
    tick();
    chk("add_wb", wb_data, 32'h1234);
    chk("add_rd", rd_o, 5);
    chk("add_we", rwe, 1);

    // JAL: link value written back
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h999; pc_plus4_Q103H = 32'h80;
    rd_Q103H = 5'd1; reg_write_en_Q103H = 1'b1; wb_sel_Q103H = 2'b10;
    tick();
    chk("jal_wb", wb_data, 32'h80);
    chk("jal_rd", rd_o, 1);

    // SB at 0x103, ready immediate
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h103; store_data_Q103H = 32'h0000_00AB;
    mem_wr_en_Q103H = 1'b1; mem_size_Q103H = 2'b00; dmem_req_ready = 1'b1;
    #1;
    chk("sb_req", req_valid, 1);
    chk("sb_addr", addr, 32'h100);
    chk("sb_be", be, 4'b1000);
    chk("sb_wdata", wdata, 32'hABAB_ABAB);
    chk("sb_we", we, 1);
    chk("sb_stall", stall, 0);
    tick();
    chk("sb_rwe", rwe, 0);

    // SH at 0x0A, ready immediate
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h0A; store_data_Q103H = 32'h1234_5678;
    mem_wr_en_Q103H = 1'b1; mem_size_Q103H = 2'b01; dmem_req_ready = 1'b1;
    #1;
    chk("sh_be", be, 4'b1100);
    chk("sh_wdata", wdata, 32'h5678_5678);
    chk("sh_addr", addr, 32'h08);
    tick();

    // LH at 0x22: ready after 2 cycles, response 3 cycles later
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h22; rd_Q103H = 5'd7; reg_write_en_Q103H = 1'b1;
    mem_rd_en_Q103H = 1'b1; mem_size_Q103H = 2'b01; wb_sel_Q103H = 2'b01;
    #1;
    chk("lh_req_t0", req_valid, 1);
    chk("lh_be", be, 4'b1111);
    chk("lh_we", we, 0);
    chk("lh_addr", addr, 32'h20);
    chk("lh_stall_t0", stall, 1);
    tick();
    chk("lh_bubble", rwe, 0);
    #1;
    chk("lh_req_t1", req_valid, 1);
    chk("lh_stall_t1", stall, 1);
    tick();
    dmem_req_ready = 1'b1;
    #1;
    chk("lh_stall_t2", stall, 1);
    tick();
    dmem_req_ready = 1'b0;
    #1;
    chk("lh_req_t3", req_valid, 0);
    chk("lh_stall_t3", stall, 1);
    tick();
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h8001_7FFF;
    dmem_rsp_valid = 1'b0;
    #1;
    chk("lh_stall_t4", stall, 1);
    tick();
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h8001_7FFF;
    #1;
    chk("lh_stall_t5", stall, 0);
    tick();
    chk("lh_wb", wb_data, 32'hFFFF_8001);
    chk("lh_rd", rd_o, 7);
    chk("lh_rwe", rwe, 1);

    do_load("lhu", 32'h22, 2'b01, 1'b1, 5'd7, 32'h8001_7FFF, 32'h0000_8001, 1'b1);
    do_load("lb",  32'h11, 2'b00, 1'b0, 5'd8, 32'h0000_F600, 32'hFFFF_FFF6, 1'b1);
    do_load("lw",  32'h44, 2'b10, 1'b0, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    do_load("lrd0", 32'h48, 2'b10, 1'b0, 5'd0, 32'h1111_2222, 32'h1111_2222, 1'b0);

    // Misaligned LW at 0x41
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h41; rd_Q103H = 5'd6; reg_write_en_Q103H = 1'b1;
    mem_rd_en_Q103H = 1'b1; mem_size_Q103H = 2'b10; wb_sel_Q103H = 2'b01;
    #1;
    chk("mis_req", req_valid, 0);
    chk("mis_stall", stall, 0);
    tick();
    chk("mis_flag", mis, 1);
    chk("mis_rwe", rwe, 0);
    chk("mis_to", tmo, 0);
    clear_in();
    tick();
    chk("mis_pulse", mis, 0);

    // SW at 0x200 with one cycle of ready delay
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h200; store_data_Q103H = 32'hCAFE_F00D;
    rd_Q103H = 5'd9; mem_wr_en_Q103H = 1'b1; mem_size_Q103H = 2'b10;
    #1;
    chk("sw_stall_t0", stall, 1);
    tick();
    #1;
    chk("sw_req_t1", req_valid, 1);
    chk("sw_addr", addr, 32'h200);
    chk("sw_wdata", wdata, 32'hCAFE_F00D);
    chk("sw_be", be, 4'b1111);
    dmem_req_ready = 1'b1;
    #1;
    chk("sw_stall_t1", stall, 0);
    tick();
    chk("sw_rwe", rwe, 0);
    chk("sw_wb", wb_data, 32'h200);

    // Reset while a load waits for its response
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h30; rd_Q103H = 5'd2; reg_write_en_Q103H = 1'b1;
    mem_rd_en_Q103H = 1'b1; mem_size_Q103H = 2'b10; wb_sel_Q103H = 2'b01; dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    #1;
    chk("rstw_stall", stall, 1);
    clear_in();
    rst = 1'b1;
    tick();
    chk("rstw_wb", wb_data, 0);
    chk("rstw_rd", rd_o, 0);
    chk("rstw_rwe", rwe, 0);
    rst = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h7777_7777;
    #1;
    chk("rstw_req", req_valid, 0);
    tick();
    chk("rstw_late_rwe", rwe, 0);
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h55; rd_Q103H = 5'd3; reg_write_en_Q103H = 1'b1;
    #1;
    chk("rstw_add_stall", stall, 0);
    tick();
    chk("rstw_add_wb", wb_data, 32'h55);
    chk("rstw_add_rwe", rwe, 1);

    // Timeout on the MAX_WAIT=4 instance: load accepted, no response
    clear_in();
    valid_Q103H = 1'b1; alu_out_Q103H = 32'h60; rd_Q103H = 5'd4; reg_write_en_Q103H = 1'b1;
    mem_rd_en_Q103H = 1'b1; mem_size_Q103H = 2'b10; wb_sel_Q103H = 2'b01; dmem_req_ready = 1'b1;
    #1;
    chk("to_req", t4_req_valid, 1);
    chk("to_addr", t4_addr, 32'h60);
    chk("to_be", t4_be, 4'b1111);
    chk("to_we", t4_we, 0);
    chk("to_wdata", t4_wdata, 0);
    chk("to_stall_t0", t4_stall, 1);
    tick();
    dmem_req_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("to_stall_t%0d", i), t4_stall, 1);
      tick();
      chk($sformatf("to_early_t%0d", i), t4_tmo, 0);
    end
    #1;
    chk("to_stall_t4", t4_stall, 0);
    tick();
    chk("to_pulse", t4_tmo, 1);
    chk("to_rwe", t4_rwe, 0);
    chk("to_mis", t4_mis, 0);
    chk("to_rd", t4_rd, 4);
    chk("to_wb", t4_wb_data, 0);
    clear_in();
    dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h5555_5555;
    #1;
    chk("to_idle_req", t4_req_valid, 0);
    tick();
    chk("to_pulse_end", t4_tmo, 0);
    chk("to_late_rwe", t4_rwe, 0);
    clear_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
